multi_phase_clk_gen: RTL and testbench
======================================

// Module: multi_phase_clk_gen
// PURPOSE
//  Synthesizable, run-time programmable multi-channel clock/pulse generator. Each channel
//  produces a periodic waveform with its own phase offset, high time and low time, counted
//  in cycles of clk. Successor to the behavioural single-channel phase/ton/toff generator,
//  now configurable per channel and restartable. Drives derived strobes/test clocks for DUT benches.
// PARAMETERS
//  NCH  4  number of independent output channels (>=1)
//  CW   8  width of phase/ton/toff counters; each field ranges 0..2^CW-1 cycles
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_n      in   1              synchronous active-low reset
//  start      in   1              1-cycle pulse: (re)start all channels, phase-aligned
//  stop       in   1              1-cycle pulse: halt all channels, outputs low
//  cfg_we     in   1              write cfg_* into shadow registers of channel cfg_ch
//  cfg_ch     in   $clog2(NCH)    target channel (use width 1 when NCH==1); ch>=NCH ignored
//  cfg_phase  in   CW             cycles from start to first high
//  cfg_ton    in   CW             high time in cycles
//  cfg_toff   in   CW             low time in cycles
//  clk_out    out  NCH            registered waveform per channel
//  rise       out  NCH            1-cycle pulse, same cycle clk_out[i] first reads 1 per high phase
//  busy       out  1              any channel not IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all channels IDLE; clk_out=0, rise=0, busy=0; shadow and active
//    cfg = phase 0, ton 1, toff 1 (default is a clk/2 waveform).
//  - Per-channel FSM: IDLE, PHASE, HIGH, LOW. clk_out[i]=1 only in HIGH. Down-counter cnt[CW-1:0].
//  - Edge sampling start=1 (stop=0): shadow->active copy for all channels, then per channel:
//      ton==0            -> IDLE, clk_out 0 (channel disabled)
//      phase>0           -> PHASE, cnt=phase-1; clk_out low for exactly phase cycles
//      phase==0          -> HIGH, cnt=ton-1; clk_out=1 visible immediately after that edge
//  - PHASE: cnt==0 -> HIGH, cnt=ton-1; else cnt--.
//  - HIGH: cnt==0 -> (toff==0 ? HIGH, cnt=ton-1 : LOW, cnt=toff-1); else cnt--.
//    toff==0 gives constant high after phase; rise pulses only on first entry.
//  - LOW: cnt==0 -> period boundary: shadow->active copy for this channel (phase field
//    ignored until next start); if new ton==0 -> IDLE else HIGH, cnt=ton-1. Else cnt--.
//  - Period = ton+toff cycles; high exactly ton cycles, low exactly toff cycles.
//  - rise[i]=1 for one cycle on every transition into HIGH from PHASE, LOW or start.
//  - start while running: hard restart, all channels re-phased from that edge (no glitch
//    merging required; a HIGH may be truncated).
//  - stop=1: all channels -> IDLE, clk_out=0, rise=0 next edge; stop beats simultaneous start.
//  - cfg_we: writes shadow only; never disturbs active counters mid-period. cfg_we in same
//    cycle as start: shadow written, the start copy uses the OLD shadow value.
//  - rst_n=0 mid-operation dominates start/stop/cfg_we; full reset state next edge.
//  - busy = |(state!=IDLE), registered with the states (no extra latency).
//  - No arithmetic overflow: counters only decrement, loads are CW-bit fields minus 1 when nonzero.
// TESTING
//  1 Reset defaults, NCH=4 CW=8: start -> all clk_out toggle 1,0,1,0 (period 2), rise every 2 cycles.
//  2 ch0 phase=0 ton=3 toff=2, ch1 phase=4 ton=1 toff=4: start at cycle T -> ch0 high T+1..T+3,
//    low T+4..T+5; ch1 low T+1..T+4, high T+5, period 5; rise aligned with first high cycle.
//  3 Running ch0 ton=3 toff=2; cfg_we ch0 ton=5 toff=5 mid-HIGH -> current period unchanged,
//    new 5/5 waveform starts exactly at next period boundary.
//  4 ton=0 on ch2 then start -> clk_out[2] stays 0, rise[2] never; toff=0 on ch3 -> constant 1 after phase.
//  5 start+stop same cycle while running -> all IDLE, clk_out=0, busy=0; start alone mid-LOW
//    -> immediate re-phase from that edge.
//  6 rst_n low for 1 cycle mid-HIGH -> clk_out=0, busy=0, cfg back to 0/1/1; cfg_ch=NCH ignored.

Source files
------------

// File: rtl/multi_phase_clk_gen.sv
// Run-time programmable multi-channel clock/pulse generator: each channel produces a
// phase-offset waveform with programmable high/low times, counted in clk cycles.
module multi_phase_clk_gen #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CW-1:0]   cfg_phase,
  input  logic [CW-1:0]   cfg_ton,
  input  logic [CW-1:0]   cfg_toff,
  output logic [NCH-1:0]  clk_out,
  output logic [NCH-1:0]  rise,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  state_t        state_r    [NCH];
  state_t        state_s    [NCH];
  logic [CW-1:0] cnt_r      [NCH];
  logic [CW-1:0] cnt_s      [NCH];
  logic [CW-1:0] sh_phase_r [NCH];
  logic [CW-1:0] sh_ton_r   [NCH];
  logic [CW-1:0] sh_toff_r  [NCH];
  logic [CW-1:0] act_ton_r  [NCH];
  logic [CW-1:0] act_toff_r [NCH];
  logic [CW-1:0] act_ton_s  [NCH];
  logic [CW-1:0] act_toff_s [NCH];
  logic [NCH-1:0] clk_out_r, clk_out_s;
  logic [NCH-1:0] rise_r, rise_s;
  logic           busy_r, busy_s;

  // Counter reload value for a field; zero fields never reach a load path but stay safe.
  function automatic logic [CW-1:0] load_val(input logic [CW-1:0] v);
    return (v == '0) ? '0 : (v - CNT_ONE);
  endfunction

  // Per-channel next state, counter and active-config selection.
  always_comb begin
    busy_s    = 1'b0;
    clk_out_s = '0;
    rise_s    = '0;
    for (int i = 0; i < NCH; i++) begin
      state_s[i]    = state_r[i];
      cnt_s[i]      = cnt_r[i];
      act_ton_s[i]  = act_ton_r[i];
      act_toff_s[i] = act_toff_r[i];
      if (stop) begin
        state_s[i] = ST_IDLE;
        cnt_s[i]   = '0;
      end else if (start) begin
        // Restart copies the shadow as it stood before any same-cycle cfg write.
        act_ton_s[i]  = sh_ton_r[i];
        act_toff_s[i] = sh_toff_r[i];
        if (sh_ton_r[i] == '0) begin
          state_s[i] = ST_IDLE;
          cnt_s[i]   = '0;
        end else if (sh_phase_r[i] != '0) begin
          state_s[i] = ST_PHASE;
          cnt_s[i]   = load_val(sh_phase_r[i]);
        end else begin
          state_s[i] = ST_HIGH;
          cnt_s[i]   = load_val(sh_ton_r[i]);
        end
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            state_s[i] = ST_IDLE;
          end
          ST_PHASE: begin
            if (cnt_r[i] == '0) begin
              state_s[i] = ST_HIGH;
              cnt_s[i]   = load_val(act_ton_r[i]);
            end else begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (cnt_r[i] != '0) begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end else if (act_toff_r[i] == '0) begin
              state_s[i] = ST_HIGH;
              cnt_s[i]   = load_val(act_ton_r[i]);
            end else begin
              state_s[i] = ST_LOW;
              cnt_s[i]   = load_val(act_toff_r[i]);
            end
          end
          ST_LOW: begin
            if (cnt_r[i] != '0) begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
              // Period boundary: pick up the latest shadow ton/toff for this channel.
              act_ton_s[i]  = sh_ton_r[i];
              act_toff_s[i] = sh_toff_r[i];
              if (sh_ton_r[i] == '0) begin
                state_s[i] = ST_IDLE;
                cnt_s[i]   = '0;
              end else begin
                state_s[i] = ST_HIGH;
                cnt_s[i]   = load_val(sh_ton_r[i]);
              end
            end
          end
          default: begin
            state_s[i] = ST_IDLE;
            cnt_s[i]   = '0;
          end
        endcase
      end
      clk_out_s[i] = (state_s[i] == ST_HIGH);
      rise_s[i]    = (state_s[i] == ST_HIGH) && ((state_r[i] != ST_HIGH) || start);
      busy_s       = busy_s | (state_s[i] != ST_IDLE);
    end
  end

  // Channel state, counters, active config and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i]    <= ST_IDLE;
        cnt_r[i]      <= '0;
        act_ton_r[i]  <= CNT_ONE;
        act_toff_r[i] <= CNT_ONE;
      end
      clk_out_r <= '0;
      rise_r    <= '0;
      busy_r    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i]    <= state_s[i];
        cnt_r[i]      <= cnt_s[i];
        act_ton_r[i]  <= act_ton_s[i];
        act_toff_r[i] <= act_toff_s[i];
      end
      clk_out_r <= clk_out_s;
      rise_r    <= rise_s;
      busy_r    <= busy_s;
    end
  end

  // Shadow configuration; channel numbers at or above NCH match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sh_phase_r[i] <= '0;
        sh_ton_r[i]   <= CNT_ONE;
        sh_toff_r[i]  <= CNT_ONE;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_ch == CHW'(i))) begin
          sh_phase_r[i] <= cfg_phase;
          sh_ton_r[i]   <= cfg_ton;
          sh_toff_r[i]  <= cfg_toff;
        end else begin
          sh_phase_r[i] <= sh_phase_r[i];
          sh_ton_r[i]   <= sh_ton_r[i];
          sh_toff_r[i]  <= sh_toff_r[i];
        end
      end
    end
  end

  assign clk_out = clk_out_r;
  assign rise    = rise_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_multi_phase_clk_gen.sv
// Scoreboard bench for multi_phase_clk_gen: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_multi_phase_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, cfg_we, cfg_we3;
  logic [1:0] cfg_ch, cfg_ch3;
  logic [7:0] cfg_phase, cfg_ton, cfg_toff;
  logic [3:0] clk_out, rise;
  logic       busy;
  logic [2:0] clk_out3, rise3;
  logic       busy3;

  always #5 clk = ~clk;

  multi_phase_clk_gen #(.NCH(4), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_phase(cfg_phase),
    .cfg_ton(cfg_ton), .cfg_toff(cfg_toff),
    .clk_out(clk_out), .rise(rise), .busy(busy)
  );

  // Three-channel instance: its 2-bit cfg_ch can address the nonexistent channel 3.
  multi_phase_clk_gen #(.NCH(3), .CW(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_phase(cfg_phase),
    .cfg_ton(cfg_ton), .cfg_toff(cfg_toff),
    .clk_out(clk_out3), .rise(rise3), .busy(busy3)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         d3;
    logic [3:0] mask;
    logic [3:0] clk;
    logic [3:0] rise;
    logic       busy;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] a_clk, a_rise;
  logic       a_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, compare each expectation due at or before this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e      = q.pop_front();
      a_clk  = e.d3 ? {1'b0, clk_out3} : clk_out;
      a_rise = e.d3 ? {1'b0, rise3} : rise;
      a_busy = e.d3 ? busy3 : busy;
      n_chk++;
      if (e.cyc == cyc && (a_clk & e.mask) == (e.clk & e.mask) &&
          (a_rise & e.mask) == (e.rise & e.mask) && a_busy == e.busy) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d (due %0d): clk_out=%b rise=%b busy=%b, required clk_out=%b rise=%b busy=%b mask=%b",
                 e.name, cyc, e.cyc, a_clk, a_rise, a_busy, e.clk, e.rise, e.busy, e.mask);
      end
    end
  end

  task automatic push(input int c, input string nm, input bit d3, input logic [3:0] m,
                      input logic [3:0] cl, input logic [3:0] ri, input logic bu);
    exp_t x;
    x.cyc = c; x.name = nm; x.d3 = d3; x.mask = m; x.clk = cl; x.rise = ri; x.busy = bu;
    q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    step(1);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic write_cfg(input int ch, input int ph, input int ton, input int toff);
    cfg_we = 1'b1; cfg_ch = 2'(ch);
    cfg_phase = 8'(ph); cfg_ton = 8'(ton); cfg_toff = 8'(toff);
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int s, s2;
    logic c0, r0, c1, c2, c3;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
    cfg_ch = 2'd0; cfg_ch3 = 2'd0; cfg_phase = 8'd0; cfg_ton = 8'd0; cfg_toff = 8'd0;

    // Reset state
    for (int c = 1; c <= 2; c++) begin
      push(c, "reset", 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
      push(c, "reset3", 1'b1, 4'h7, 4'h0, 4'h0, 1'b0);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    drain();

    // Defaults give clk/2 on every channel, rise on every high
    do_start(s);
    for (int k = 0; k < 6; k++) begin
      c0 = (k % 2 == 0);
      push(s + k, "t1_default", 1'b0, 4'hF, {4{c0}}, {4{c0}}, 1'b1);
    end
    drain();

    // ch0 0/3/2, ch1 4/1/4, ch2/ch3 still default
    write_cfg(0, 0, 3, 2);
    write_cfg(1, 4, 1, 4);
    do_start(s);
    for (int k = 0; k < 10; k++) begin
      c0 = (k % 5) < 3; r0 = (k % 5) == 0; c1 = (k % 5) == 4; c2 = (k % 2) == 0;
      push(s + k, "t2_phase_ton_toff", 1'b0, 4'hF, {c2, c2, c1, c0}, {c2, c2, c1, r0}, 1'b1);
    end
    drain();

    // Mid-HIGH rewrite of ch0 to 5/5 takes effect only at the next period boundary
    do_start(s);
    for (int k = 0; k < 17; k++) begin
      if (k < 5) begin
        c0 = (k < 3); r0 = (k == 0);
      end else begin
        c0 = ((k - 5) % 10) < 5; r0 = ((k - 5) % 10) == 0;
      end
      push(s + k, "t3_shadow_boundary", 1'b0, 4'h1, {3'b000, c0}, {3'b000, r0}, 1'b1);
    end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_phase = 8'd0; cfg_ton = 8'd5; cfg_toff = 8'd5;
    step(1);
    cfg_we = 1'b0;
    drain();

    // ch2 ton=0 disabled; ch3 phase 2, toff=0 -> constant high, single rise
    write_cfg(2, 0, 0, 1);
    write_cfg(3, 2, 1, 0);
    do_start(s);
    for (int k = 0; k < 8; k++) begin
      c3 = (k >= 2);
      push(s + k, "t4_ton0_toff0", 1'b0, 4'hC, {c3, 3'b000}, {k == 2, 3'b000}, 1'b1);
    end
    drain();

    // stop beats simultaneous start
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    s = cyc;
    for (int k = 0; k < 3; k++) push(s + k, "t5_stop_wins", 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    drain();

    // Restart during ch1 LOW re-phases every channel from that edge
    do_start(s);
    for (int k = 0; k < 6; k++) begin
      c0 = (k < 5); c1 = (k == 4);
      push(s + k, "t5_run", 1'b0, 4'h3, {2'b00, c1, c0}, {2'b00, c1, k == 0}, 1'b1);
    end
    step(5);
    do_start(s2);
    for (int k = 0; k < 10; k++) begin
      c0 = (k < 5); c1 = (k == 4) || (k == 9);
      push(s2 + k, "t5_rephase", 1'b0, 4'h3, {2'b00, c1, c0}, {2'b00, c1, k == 0}, 1'b1);
    end
    drain();

    // Reset mid-HIGH restores all config; write to channel NCH on the 3-channel instance ignored
    do_start(s);
    push(s, "t6_pre", 1'b0, 4'h1, 4'h1, 4'h1, 1'b1);
    push(s + 1, "t6_pre", 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
    step(1);
    rst_n = 1'b0;
    push(s + 2, "t6_reset", 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    push(s + 2, "t6_reset3", 1'b1, 4'h7, 4'h0, 4'h0, 1'b0);
    push(s + 3, "t6_idle", 1'b0, 4'hF, 4'h0, 4'h0, 1'b0);
    step(1);
    rst_n = 1'b1;
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_phase = 8'd0; cfg_ton = 8'd0; cfg_toff = 8'd0;
    step(1);
    cfg_we3 = 1'b0;
    // Same-cycle write with start: start uses old (default) shadow, ton=0 lands at boundary
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_phase = 8'd0; cfg_ton = 8'd0; cfg_toff = 8'd1;
    do_start(s);
    cfg_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c0 = (k == 0); c2 = (k % 2) == 0;
      push(s + k, "t6_defaults", 1'b0, 4'hF, {c2, c2, c2, c0}, {c2, c2, c2, c0}, 1'b1);
      push(s + k, "t6_ch_ignored", 1'b1, 4'h7, {1'b0, c2, c2, c2}, {1'b0, c2, c2, c2}, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
